axi_uart_cmd_parser: RTL and testbench

- Sits directly downstream of the UART receiver. Consumes its one-cycle byte-valid strobe and received byte, and frames the byte stream into 32-bit read/write command packets.
- Presents each completed command on a valid/ready interface to the AXI master bridge, which loads and inspects memory over the debug UART.
- Adds sync-byte framing, opcode checking, inter-byte timeout and overrun detection.

---
 rtl/axi_uart_cmd_parser.sv | 157 +++++++++++++++
 tb/tb_axi_uart_cmd_parser.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_uart_cmd_parser.sv
// axi_uart_cmd_parser
// Frames the UART receive byte stream into 32-bit read/write commands:
//   A5, opcode, addr[7:0] .. addr[31:24], then data[7:0] .. data[31:24] for writes.
// Each finished command is offered on a valid/ready port to the AXI master bridge.
// o_Err pulses once for a bad opcode, an inter-byte timeout, or a byte that
// arrives while a command is still waiting (overrun).
module axi_uart_cmd_parser #(
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter logic [7:0] OP_WRITE     = 8'h01,
   parameter logic [7:0] OP_READ      = 8'h02,
   parameter int         TIMEOUT_CLKS = 3470
) (
   input  logic        i_Clock,
   input  logic        i_Rst_L,
   input  logic        i_RX_DV,
   input  logic [7:0]  i_RX_Byte,
   output logic        o_Cmd_Valid,
   input  logic        i_Cmd_Ready,
   output logic        o_Cmd_Write,
   output logic [31:0] o_Cmd_Addr,
   output logic [31:0] o_Cmd_Data,
   output logic        o_Err,
   output logic [1:0]  o_Err_Code
);

   localparam int TW = $clog2(TIMEOUT_CLKS);
   // The counter reads 0 in the first idle cycle after a byte. The frame is
   // aborted on the edge where it would step to TIMEOUT_CLKS-1; a byte sampled
   // on that same edge still wins.
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 2);

   localparam logic [1:0] ERR_OPCODE  = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_OVERRUN = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_OPCODE = 3'd1,
      S_ADDR   = 3'd2,
      S_DATA   = 3'd3,
      S_ISSUE  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    byte_cnt_q, byte_cnt_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic          write_q, write_d;
   logic          err_q, err_d;
   logic [1:0]    err_code_q, err_code_d;
   logic          in_frame;
   logic          tmo_hit;

   // State and datapath registers; reset drops any partial or pending frame silently.
   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         write_q    <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         write_q    <= write_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   // Next-state, byte assembly, inter-byte timeout and error classification.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      write_d    = write_q;
      err_d      = 1'b0;
      err_code_d = err_code_q;

      in_frame = (state_q == S_OPCODE) || (state_q == S_ADDR) || (state_q == S_DATA);
      tmo_hit  = in_frame && !i_RX_DV && (tmo_cnt_q == TMO_LAST);

      if (in_frame)
         tmo_cnt_d = i_RX_DV ? '0 : tmo_cnt_q + TW'(1);

      case (state_q)
         S_IDLE: begin
            if (i_RX_DV && (i_RX_Byte == SYNC_BYTE))
               state_d = S_OPCODE;
         end
         S_OPCODE: begin
            if (i_RX_DV) begin
               if ((i_RX_Byte == OP_WRITE) || (i_RX_Byte == OP_READ)) begin
                  write_d    = (i_RX_Byte == OP_WRITE);
                  byte_cnt_d = '0;
                  data_d     = '0;
                  state_d    = S_ADDR;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = ERR_OPCODE;
                  state_d    = S_IDLE;
               end
            end else if (tmo_hit) begin
               err_d      = 1'b1;
               err_code_d = ERR_TIMEOUT;
               state_d    = S_IDLE;
            end
         end
         S_ADDR, S_DATA: begin
            if (i_RX_DV) begin
               if (state_q == S_ADDR)
                  addr_d[{byte_cnt_q, 3'b000} +: 8] = i_RX_Byte;
               else
                  data_d[{byte_cnt_q, 3'b000} +: 8] = i_RX_Byte;
               // 2-bit counter wraps to 0 after the 4th byte, ready for the data phase.
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3)
                  state_d = (state_q == S_ADDR && write_q) ? S_DATA : S_ISSUE;
            end else if (tmo_hit) begin
               err_d      = 1'b1;
               err_code_d = ERR_TIMEOUT;
               state_d    = S_IDLE;
            end
         end
         S_ISSUE: begin
            // Any byte here is dropped, sync included; the pending command stays intact.
            if (i_RX_DV) begin
               err_d      = 1'b1;
               err_code_d = ERR_OVERRUN;
            end
            if (i_Cmd_Ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if ((state_d == S_IDLE) || (state_d == S_ISSUE))
         tmo_cnt_d = '0;
   end

   assign o_Cmd_Valid = (state_q == S_ISSUE);
   assign o_Cmd_Write = write_q;
   assign o_Cmd_Addr  = addr_q;
   assign o_Cmd_Data  = data_q;
   assign o_Err       = err_q;
   assign o_Err_Code  = err_code_q;

endmodule

// File: tb/tb_axi_uart_cmd_parser.sv
// tb_axi_uart_cmd_parser
// Directed frames from the test plan plus randomized frames. Expected commands
// and error codes are queued from the frame fields being sent; a negedge monitor
// pops them on every transfer / error pulse and watches valid-hold stability.
module tb_axi_uart_cmd_parser;

   localparam int TMO = 40;

   logic        i_Clock = 1'b0;
   logic        i_Rst_L = 1'b1;
   logic        i_RX_DV = 1'b0;
   logic [7:0]  i_RX_Byte = 8'h00;
   logic        i_Cmd_Ready = 1'b0;
   logic        o_Cmd_Valid;
   logic        o_Cmd_Write;
   logic [31:0] o_Cmd_Addr;
   logic [31:0] o_Cmd_Data;
   logic        o_Err;
   logic [1:0]  o_Err_Code;

   axi_uart_cmd_parser #(.TIMEOUT_CLKS(TMO)) dut (
      .i_Clock     (i_Clock),
      .i_Rst_L     (i_Rst_L),
      .i_RX_DV     (i_RX_DV),
      .i_RX_Byte   (i_RX_Byte),
      .o_Cmd_Valid (o_Cmd_Valid),
      .i_Cmd_Ready (i_Cmd_Ready),
      .o_Cmd_Write (o_Cmd_Write),
      .o_Cmd_Addr  (o_Cmd_Addr),
      .o_Cmd_Data  (o_Cmd_Data),
      .o_Err       (o_Err),
      .o_Err_Code  (o_Err_Code)
   );

   always #5 i_Clock = ~i_Clock;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } cmd_t;

   cmd_t       exp_cmd[$];
   logic [1:0] exp_err[$];
   int         n_total = 0;
   int         n_bad   = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
      end
   endtask

   // All stimulus moves 1ns after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge i_Clock);
         #1;
      end
   endtask

   // gap idle cycles, then one byte strobe sampled on the next rising edge.
   task automatic tx(input logic [7:0] b, input int gap);
      idle(gap);
      i_RX_DV   = 1'b1;
      i_RX_Byte = b;
      @(posedge i_Clock);
      #1;
      i_RX_DV   = 1'b0;
   endtask

   // Sends the first nbytes of a command frame built from its fields.
   task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input int gap, input int nbytes);
      logic [7:0] fr [10];
      int len;
      fr[0] = 8'hA5;
      fr[1] = wr ? 8'h01 : 8'h02;
      for (int i = 0; i < 4; i++) begin
         fr[2+i] = a[8*i +: 8];
         fr[6+i] = d[8*i +: 8];
      end
      len = wr ? 10 : 6;
      if (nbytes < len) len = nbytes;
      for (int i = 0; i < len; i++) tx(fr[i], gap);
   endtask

   task automatic expect_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
      cmd_t c;
      c.wr   = wr;
      c.addr = a;
      c.data = wr ? d : 32'h0;
      exp_cmd.push_back(c);
   endtask

   task automatic drain();
      for (int k = 0; k < 60 && o_Cmd_Valid; k++) idle(1);
      chk("drain_vld", {63'd0, o_Cmd_Valid}, 64'd0);
   endtask

   // Monitor: inputs are stable from posedge+1 to the next posedge, so the
   // negedge sees exactly what the coming edge will sample.
   cmd_t prev;
   logic prev_hold = 1'b0;
   cmd_t got;
   logic [1:0] ecode;
   always @(negedge i_Clock) begin
      if (!i_Rst_L) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_vld", {63'd0, o_Cmd_Valid}, 64'd1);
            chk("hold_wr", {63'd0, o_Cmd_Write}, {63'd0, prev.wr});
            chk("hold_ad", {o_Cmd_Addr, o_Cmd_Data}, {prev.addr, prev.data});
         end
         if (o_Cmd_Valid && i_Cmd_Ready) begin
            if (exp_cmd.size() == 0) begin
               chk("cmd_unexpected", 64'(exp_cmd.size()), 64'd1);
            end else begin
               got = exp_cmd.pop_front();
               chk("cmd_wr", {63'd0, o_Cmd_Write}, {63'd0, got.wr});
               chk("cmd_addr", {32'd0, o_Cmd_Addr}, {32'd0, got.addr});
               chk("cmd_data", {32'd0, o_Cmd_Data}, {32'd0, got.data});
            end
         end
         prev_hold = o_Cmd_Valid && !i_Cmd_Ready;
         prev.wr   = o_Cmd_Write;
         prev.addr = o_Cmd_Addr;
         prev.data = o_Cmd_Data;
         if (o_Err) begin
            if (exp_err.size() == 0) begin
               chk("err_unexpected", 64'(exp_err.size()), 64'd1);
            end else begin
               ecode = exp_err.pop_front();
               chk("err_code", {62'd0, o_Err_Code}, {62'd0, ecode});
            end
         end
      end
   end

   int          k, kind, ng, m, gap;
   logic        wr, rdy_hi;
   logic [31:0] a, d;
   logic [7:0]  b;

   initial begin
      // ---- reset state ----
      #2 i_Rst_L = 1'b0;
      #1;
      chk("rst_vld", {63'd0, o_Cmd_Valid}, 64'd0);
      chk("rst_err", {61'd0, o_Err, o_Err_Code}, 64'd0);
      chk("rst_ad", {o_Cmd_Addr, o_Cmd_Data}, 64'd0);
      chk("rst_wr", {63'd0, o_Cmd_Write}, 64'd0);
      idle(3);
      i_Rst_L = 1'b1;
      idle(2);

      // ---- write frame, ready high ----
      i_Cmd_Ready = 1'b1;
      expect_cmd(1'b1, 32'h12345678, 32'hDEADBEEF);
      send_cmd(1'b1, 32'h12345678, 32'hDEADBEEF, 1, 9);
      chk("w_pre_vld", {63'd0, o_Cmd_Valid}, 64'd0);
      tx(8'hDE, 1);
      chk("w_vld_lat", {63'd0, o_Cmd_Valid}, 64'd1);
      idle(1);
      chk("w_idle", {63'd0, o_Cmd_Valid}, 64'd0);

      // ---- read frame, ready low 20 cycles ----
      i_Cmd_Ready = 1'b0;
      expect_cmd(1'b0, 32'h80001000, 32'h0);
      send_cmd(1'b0, 32'h80001000, 32'h0, 2, 6);
      for (int i = 0; i < 20; i++) begin
         chk("r_wait_vld", {63'd0, o_Cmd_Valid}, 64'd1);
         idle(1);
      end
      i_Cmd_Ready = 1'b1;
      idle(1);
      chk("r_done", {63'd0, o_Cmd_Valid}, 64'd0);

      // ---- garbage + bad opcode, then a good read ----
      tx(8'h00, 2);
      tx(8'hFF, 2);
      tx(8'hA5, 2);
      exp_err.push_back(2'b01);
      tx(8'h03, 2);
      chk("badop_err", {61'd0, o_Err, o_Err_Code}, {61'd0, 1'b1, 2'b01});
      idle(5);
      chk("code_hold", {61'd0, o_Err, o_Err_Code}, {61'd0, 1'b0, 2'b01});
      expect_cmd(1'b0, 32'hCAFE0042, 32'h0);
      send_cmd(1'b0, 32'hCAFE0042, 32'h0, 1, 6);
      drain();

      // ---- timeout: pulse TMO-1 edges after the last byte ----
      exp_err.push_back(2'b10);
      tx(8'hA5, 1); tx(8'h01, 1); tx(8'h11, 1); tx(8'h22, 1);
      k = 0;
      while (k < TMO + 5) begin
         idle(1);
         k++;
         if (o_Err) break;
      end
      chk("tmo_lat", 64'(k), 64'(TMO - 1));
      chk("tmo_code", {62'd0, o_Err_Code}, 64'd2);
      idle(3);
      expect_cmd(1'b1, 32'h0BADF00D, 32'h00C0FFEE);
      send_cmd(1'b1, 32'h0BADF00D, 32'h00C0FFEE, 1, 10);
      drain();

      // ---- byte on the terminal-count cycle wins ----
      expect_cmd(1'b1, 32'h44332211, 32'h88776655);
      send_cmd(1'b1, 32'h44332211, 32'h88776655, TMO - 2, 10);
      drain();

      // ---- overrun while waiting, and on the handshake cycle ----
      i_Cmd_Ready = 1'b0;
      expect_cmd(1'b0, 32'h13579BDF, 32'h0);
      send_cmd(1'b0, 32'h13579BDF, 32'h0, 1, 6);
      exp_err.push_back(2'b11);
      tx(8'h5A, 2);
      chk("ovr1", {61'd0, o_Err, o_Err_Code}, {61'd0, 1'b1, 2'b11});
      exp_err.push_back(2'b11);
      tx(8'hA5, 2);
      idle(3);
      chk("ovr_addr", {32'd0, o_Cmd_Addr}, 64'h13579BDF);
      exp_err.push_back(2'b11);
      i_Cmd_Ready = 1'b1;
      tx(8'h77, 0);
      chk("ovr_hs", {61'd0, o_Cmd_Valid, o_Err, o_Err_Code}, {61'd0, 1'b0, 1'b1, 2'b11});
      idle(2);

      // ---- reset after 7th byte of a write ----
      send_cmd(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 7);
      i_Rst_L = 1'b0;
      #1;
      chk("mrst_out", {o_Cmd_Addr, o_Cmd_Data}, 64'd0);
      chk("mrst_ctl", {60'd0, o_Cmd_Valid, o_Cmd_Write, o_Err_Code}, 64'd0);
      idle(2);
      i_Rst_L = 1'b1;
      idle(1);
      expect_cmd(1'b0, 32'h00A000B0, 32'h0);
      send_cmd(1'b0, 32'h00A000B0, 32'h0, 1, 6);
      drain();

      // ---- reset while a command is pending ----
      i_Cmd_Ready = 1'b0;
      send_cmd(1'b0, 32'h11111111, 32'h0, 1, 6);
      chk("issue_vld", {63'd0, o_Cmd_Valid}, 64'd1);
      i_Rst_L = 1'b0;
      #1;
      chk("issue_rst", {63'd0, o_Cmd_Valid}, 64'd0);
      idle(2);
      i_Rst_L = 1'b1;
      i_Cmd_Ready = 1'b1;
      idle(2);

      // ---- randomized frames ----
      for (int it = 0; it < 30; it++) begin
         kind = $urandom_range(0, 5);
         ng   = $urandom_range(0, 2);
         for (int g = 0; g < ng; g++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            tx(b, $urandom_range(0, 3));
         end
         wr = 1'($urandom_range(0, 1));
         a  = $urandom;
         d  = $urandom;
         case ($urandom_range(0, 3))
            0: gap = 0;
            1: gap = 1;
            2: gap = 5;
            default: gap = TMO - 2;
         endcase
         if (kind == 0) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h01 || b == 8'h02) b = 8'h03;
            exp_err.push_back(2'b01);
            tx(8'hA5, gap);
            tx(b, gap);
         end else if (kind == 1) begin
            m = $urandom_range(1, wr ? 9 : 5);
            exp_err.push_back(2'b10);
            send_cmd(wr, a, d, gap, m);
            idle(TMO + $urandom_range(0, 3));
         end else begin
            rdy_hi = 1'($urandom_range(0, 1));
            i_Cmd_Ready = rdy_hi;
            expect_cmd(wr, a, d);
            send_cmd(wr, a, d, gap, 10);
            if (!rdy_hi) begin
               if ($urandom_range(0, 2) == 0) begin
                  exp_err.push_back(2'b11);
                  tx(8'($urandom_range(0, 255)), $urandom_range(0, 3));
               end
               idle($urandom_range(0, 5));
               i_Cmd_Ready = 1'b1;
            end
         end
         drain();
      end

      idle(5);
      chk("cmd_left", 64'(exp_cmd.size()), 64'd0);
      chk("err_left", 64'(exp_err.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
